// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the asynchronous SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrSetup,
        StWrPulse,
        StWrHold
    } sram_state_t;

    // Width of the shared wait counter: enough to hold the longer of the two wait phases.
    function automatic int unsigned cnt_width(input int unsigned rd_wait,
                                              input int unsigned wr_wait);
        int unsigned mx;
        mx = (rd_wait > wr_wait) ? rd_wait : wr_wait;
        return (mx < 1) ? 1 : $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// Loadable down-counter; done flags the last cycle of a timed phase.
module sram_wait_timer #(
    parameter int unsigned W = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/sram_ctrl.sv
// Multi-cycle asynchronous SRAM controller with a valid/ready request port and a response pulse.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                resp_valid,
    output logic                resp_we,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                CE_n,
    output logic                OE_n,
    output logic                WE_n,
    output logic [DATA_W/8-1:0] BE_n,
    output logic [ADDR_W-1:0]   ADDR,
    output logic [DATA_W-1:0]   data_to_sram,
    output logic                data_oe,
    input  logic [DATA_W-1:0]   data_from_sram
);

    localparam int unsigned CNT_W = cnt_width(RD_WAIT, WR_WAIT);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT);

    sram_state_t      state;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;

    assign req_ready = (state == StIdle) && !Reset;

    // Timer is loaded on entry to READ (at accept) and on entry to WR_PULSE.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = RD_LOAD;
        if (state == StIdle && req_valid && !req_we) begin
            tmr_load = 1'b1;
            tmr_val  = RD_LOAD;
        end else if (state == StWrSetup) begin
            tmr_load = 1'b1;
            tmr_val  = WR_LOAD;
        end
    end

    sram_wait_timer #(
        .W (CNT_W)
    ) u_timer (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= StIdle;
            CE_n         <= 1'b1;
            OE_n         <= 1'b1;
            WE_n         <= 1'b1;
            BE_n         <= '1;
            ADDR         <= '0;
            data_to_sram <= '0;
            data_oe      <= 1'b0;
            resp_valid   <= 1'b0;
            resp_we      <= 1'b0;
            resp_rdata   <= '0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        ADDR <= req_addr;
                        CE_n <= 1'b0;
                        if (req_we) begin
                            state        <= StWrSetup;
                            BE_n         <= ~req_be;
                            data_to_sram <= req_wdata;
                            data_oe      <= 1'b1;
                        end else begin
                            state <= StRead;
                            OE_n  <= 1'b0;
                            BE_n  <= '0;
                        end
                    end
                end
                StRead: begin
                    if (tmr_done) begin
                        state      <= StIdle;
                        resp_rdata <= data_from_sram;
                        resp_valid <= 1'b1;
                        resp_we    <= 1'b0;
                        CE_n       <= 1'b1;
                        OE_n       <= 1'b1;
                        BE_n       <= '1;
                    end
                end
                StWrSetup: begin
                    state <= StWrPulse;
                    WE_n  <= 1'b0;
                end
                StWrPulse: begin
                    if (tmr_done) begin
                        state <= StWrHold;
                        WE_n  <= 1'b1;
                    end
                end
                StWrHold: begin
                    state      <= StIdle;
                    resp_valid <= 1'b1;
                    resp_we    <= 1'b1;
                    data_oe    <= 1'b0;
                    CE_n       <= 1'b1;
                    BE_n       <= '1;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a small byte-lane SRAM model on the pins.
module tb_sram_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [19:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be = '0;
    logic        resp_valid;
    logic        resp_we;
    logic [15:0] resp_rdata;
    logic        CE_n;
    logic        OE_n;
    logic        WE_n;
    logic [1:0]  BE_n;
    logic [19:0] ADDR;
    logic [15:0] data_to_sram;
    logic        data_oe;
    logic [15:0] data_from_sram;

    int total = 0;
    int bad = 0;
    int oe_clash = 0;
    logic we_n_prev = 1'b1;
    logic [15:0] mem [256];

    always #5 Clk = ~Clk;

    sram_ctrl dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_be         (req_be),
        .resp_valid     (resp_valid),
        .resp_we        (resp_we),
        .resp_rdata     (resp_rdata),
        .CE_n           (CE_n),
        .OE_n           (OE_n),
        .WE_n           (WE_n),
        .BE_n           (BE_n),
        .ADDR           (ADDR),
        .data_to_sram   (data_to_sram),
        .data_oe        (data_oe),
        .data_from_sram (data_from_sram)
    );

    assign data_from_sram = (!CE_n && !OE_n) ? mem[ADDR[7:0]] : 16'h0000;

    // SRAM latches on the WE_n rising edge, but only if data is still driven (hold satisfied).
    always @(negedge Clk) begin
        if (!OE_n && data_oe) oe_clash++;
        if (WE_n && !we_n_prev && data_oe && !CE_n) begin
            if (!BE_n[0]) mem[ADDR[7:0]][7:0]  = data_to_sram[7:0];
            if (!BE_n[1]) mem[ADDR[7:0]][15:8] = data_to_sram[15:8];
        end
        we_n_prev = WE_n;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Single isolated transaction; returns latency (-1 on timeout) and per-cycle strobe counts.
    task automatic run_op(input logic we, input logic [19:0] addr, input logic [15:0] wd,
                          input logic [1:0] be, output int lat, output int n_we,
                          output int n_oe, output int n_doe, output logic [1:0] be_seen,
                          output logic rwe, output logic [15:0] rd);
        int k;
        lat = -1; n_we = 0; n_oe = 0; n_doe = 0; be_seen = 2'b11; rwe = 1'bx; rd = 'x;
        @(negedge Clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge Clk);
            k++;
        end
        @(posedge Clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge Clk);
            if (!WE_n) begin
                n_we++;
                be_seen = BE_n;
            end
            if (!OE_n) n_oe++;
            if (data_oe) n_doe++;
            if (resp_valid) begin
                lat = c;
                rwe = resp_we;
                rd = resp_rdata;
                break;
            end
        end
    endtask

    int lat, n_we, n_oe, n_doe;
    logic [1:0] be_seen;
    logic rwe;
    logic [15:0] rd;
    int acc_cyc [3];
    int resp_cyc [3];
    logic [15:0] resp_rd [3];
    logic op_we [3];
    logic [19:0] op_addr [3];
    logic [15:0] op_wd [3];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        // Reset values, sampled while Reset is still high
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_eq("rst_strobes", 32'({CE_n, OE_n, WE_n, BE_n}), 32'h1F);
        check_eq("rst_doe_resp", 32'({data_oe, resp_valid, resp_we}), 32'h0);
        check_eq("rst_rdata", 32'(resp_rdata), 32'h0);
        check_eq("rst_addr_data", 32'(ADDR) | 32'(data_to_sram), 32'h0);
        check_eq("rst_ready_low", 32'(req_ready), 32'h0);
        Reset = 1'b0;
        @(negedge Clk);
        check_eq("idle_ready", 32'(req_ready), 32'h1);
        check_eq("idle_strobes", 32'({CE_n, OE_n, WE_n, data_oe}), 32'hE);

        // Full-word write
        run_op(1'b1, 20'h00123, 16'hBEEF, 2'b11, lat, n_we, n_oe, n_doe, be_seen, rwe, rd);
        check_eq("wr_lat", 32'(lat), 32'd5);
        check_eq("wr_we_cycles", 32'(n_we), 32'd2);
        check_eq("wr_doe_cycles", 32'(n_doe), 32'd4);
        check_eq("wr_oe_cycles", 32'(n_oe), 32'd0);
        check_eq("wr_be_n", 32'(be_seen), 32'h0);
        check_eq("wr_resp_we", 32'(rwe), 32'h1);
        check_eq("wr_mem", 32'(mem[8'h23]), 32'hBEEF);
        check_eq("wr_addr_held", 32'(ADDR), 32'h00123);

        // Read back
        run_op(1'b0, 20'h00123, 16'h0000, 2'b00, lat, n_we, n_oe, n_doe, be_seen, rwe, rd);
        check_eq("rd_lat", 32'(lat), 32'd3);
        check_eq("rd_data", 32'(rd), 32'hBEEF);
        check_eq("rd_oe_cycles", 32'(n_oe), 32'd2);
        check_eq("rd_doe_cycles", 32'(n_doe), 32'd0);
        check_eq("rd_resp_we", 32'(rwe), 32'h0);

        // Low-byte-only write
        run_op(1'b1, 20'h00123, 16'h1234, 2'b01, lat, n_we, n_oe, n_doe, be_seen, rwe, rd);
        check_eq("wrb_lat", 32'(lat), 32'd5);
        check_eq("wrb_be_n", 32'(be_seen), 32'h2);
        check_eq("wrb_rdata_held", 32'(rd), 32'hBEEF);
        run_op(1'b0, 20'h00123, 16'h0000, 2'b00, lat, n_we, n_oe, n_doe, be_seen, rwe, rd);
        check_eq("wrb_readback", 32'(rd), 32'hBE34);

        // Zero byte-enable write: full timing, memory untouched
        run_op(1'b1, 20'h00123, 16'hFFFF, 2'b00, lat, n_we, n_oe, n_doe, be_seen, rwe, rd);
        check_eq("be0_lat", 32'(lat), 32'd5);
        check_eq("be0_be_n", 32'(be_seen), 32'h3);
        check_eq("be0_mem", 32'(mem[8'h23]), 32'hBE34);

        // Back-to-back with req_valid held: read, write, read
        op_we[0] = 1'b0; op_addr[0] = 20'h00123; op_wd[0] = 16'h0000;
        op_we[1] = 1'b1; op_addr[1] = 20'h00045; op_wd[1] = 16'hA5A5;
        op_we[2] = 1'b0; op_addr[2] = 20'h00045; op_wd[2] = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            acc_cyc[i] = -100; resp_cyc[i] = -100; resp_rd[i] = 'x;
        end
        begin
            int idx, nresp;
            logic acc;
            idx = 0; nresp = 0;
            @(negedge Clk);
            req_valid = 1'b1; req_we = op_we[0]; req_addr = op_addr[0];
            req_wdata = op_wd[0]; req_be = 2'b11;
            for (int cyc = 0; cyc < 40 && nresp < 3; cyc++) begin
                acc = req_valid && req_ready;
                if (resp_valid) begin
                    resp_cyc[nresp] = cyc;
                    resp_rd[nresp] = resp_rdata;
                    nresp++;
                end
                if (acc) begin
                    acc_cyc[idx] = cyc;
                    idx++;
                end
                @(posedge Clk);
                #1;
                if (acc) begin
                    if (idx < 3) begin
                        req_we = op_we[idx]; req_addr = op_addr[idx]; req_wdata = op_wd[idx];
                    end else begin
                        req_valid = 1'b0;
                    end
                end
                @(negedge Clk);
            end
            req_valid = 1'b0;
        end
        check_eq("b2b_acc1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        check_eq("b2b_acc2", 32'(acc_cyc[2] - acc_cyc[0]), 32'd8);
        check_eq("b2b_resp_last", 32'(resp_cyc[2] - acc_cyc[0]), 32'd11);
        check_eq("b2b_rd0", 32'(resp_rd[0]), 32'hBE34);
        check_eq("b2b_rd2", 32'(resp_rd[2]), 32'hA5A5);

        // Reset during the second WR_PULSE cycle aborts the write
        @(negedge Clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h00123; req_wdata = 16'h5A5A;
        req_be = 2'b11;
        @(posedge Clk);
        #1 req_valid = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        check_eq("abort_pulse_active", 32'(WE_n), 32'h0);
        @(negedge Clk);
        check_eq("abort_we_n", 32'(WE_n), 32'h1);
        check_eq("abort_doe", 32'(data_oe), 32'h0);
        check_eq("abort_ce_n", 32'(CE_n), 32'h1);
        check_eq("abort_no_resp", 32'(resp_valid), 32'h0);
        Reset = 1'b0;
        @(negedge Clk);
        check_eq("abort_no_resp2", 32'(resp_valid), 32'h0);
        run_op(1'b0, 20'h00123, 16'h0000, 2'b00, lat, n_we, n_oe, n_doe, be_seen, rwe, rd);
        check_eq("abort_readback", 32'(rd), 32'hBE34);

        check_eq("oe_doe_exclusive", 32'(oe_clash), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Parametrised, multi-cycle asynchronous-SRAM controller for the SLC-3 memory subsystem.
- Replaces fixed single-cycle strobing with a valid/ready request port and a response pulse.
- Supports configurable read and write wait states, data width and address width, and per-byte write enables.
- Sits between the CPU datapath or Mem2IO and the existing `tristate` buffer that drives the SRAM data pins.

Parameters:
- DATA_W, 16: data width in bits; must be a multiple of 8.
- ADDR_W, 20: SRAM address width.
- RD_WAIT, 2: cycles OE_n is held low per read; must be >= 1.
- WR_WAIT, 2: cycles WE_n is held low per write; must be >= 1.

Ports:
- Clk in 1: single system clock; all logic on rising edge.
- Reset in 1: synchronous, active-high reset.
- req_valid in 1: request present.
- req_ready out 1: controller can accept a request.
- req_we in 1: 1 = write, 0 = read.
- req_addr in ADDR_W: word address.
- req_wdata in DATA_W: write data.
- req_be in DATA_W/8: byte enables, active high; writes only.
- resp_valid out 1: one-cycle completion pulse.
- resp_we out 1: type of the completed operation.
- resp_rdata out DATA_W: read data; holds its last value.
- CE_n out 1: SRAM chip enable, active low.
- OE_n out 1: SRAM output enable, active low.
- WE_n out 1: SRAM write enable, active low.
- BE_n out DATA_W/8: SRAM byte lanes, active low (UB/LB when DATA_W = 16).
- ADDR out ADDR_W: registered SRAM address.
- data_to_sram out DATA_W: write data to the tristate buffer.
- data_oe out 1: tristate output enable.
- data_from_sram in DATA_W: read data from the tristate buffer.

Behaviour:
- Reset is synchronous, active-high, one clock `Clk`.
- Reset values (state and all registered outputs): state IDLE; CE_n = OE_n = WE_n = 1; BE_n all 1; ADDR = 0; data_to_sram = 0; data_oe = 0; resp_valid = 0; resp_we = 0; resp_rdata = 0.
- req_ready = (state == IDLE) && !Reset.
- A request is accepted on a rising edge where req_valid && req_ready. Address, data, be and we are captured into registers at that edge.
- States: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD.
- One down-counter, width $clog2(max(RD_WAIT, WR_WAIT) + 1).
- Read:
  - Cycles 1..RD_WAIT after accept are in READ: CE_n = 0, OE_n = 0, WE_n = 1, BE_n all 0, data_oe = 0, ADDR = captured address.
  - data_from_sram is registered into resp_rdata at the end of cycle RD_WAIT.
  - Cycle RD_WAIT+1: state IDLE, resp_valid = 1, resp_we = 0, all strobes deasserted.
  - A new request may be accepted in that same cycle.
- Write:
  - Cycle 1 after accept, WR_SETUP: CE_n = 0, WE_n = 1, data_oe = 1, BE_n = ~be, address and data stable.
  - Cycles 2..WR_WAIT+1, WR_PULSE: WE_n = 0.
  - Cycle WR_WAIT+2, WR_HOLD: WE_n = 1; data_oe, data and address still held.
  - Cycle WR_WAIT+3: IDLE, resp_valid = 1, resp_we = 1, data_oe = 0.
- data_oe and OE_n are never both asserted; OE_n = 0 implies data_oe = 0.
- A write with be = 0 runs the full timing and acks normally; BE_n stays all 1, so memory is unchanged.
- req_valid while busy is ignored: not captured, and no error raised.
- Reset mid-operation: at the next edge, return to IDLE with the reset values above and abort the cycle. No resp_valid is issued for the aborted request.
- resp_rdata changes only on read completion or reset.
- ADDR holds its last value in IDLE; only CE_n deasserts.

Decomposition:
- Package `sram_ctrl_pkg`: state enum `sram_state_t` (IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD) and a localparam function for the counter width.
- Optional sub-module `sram_wait_timer`: loadable down-counter with a `done` flag, shared by the READ and WR_PULSE phases.
- The `tristate` buffer stays outside this block and is instantiated at top level.

Test Plan (defaults: DATA_W = 16, RD_WAIT = 2, WR_WAIT = 2):
- Reset, then idle -> all strobes 1, data_oe = 0, req_ready = 1 one cycle after Reset drops.
- Write addr 0x00123, data 0xBEEF, be = 2'b11 -> WE_n low for exactly 2 cycles, data_oe high for 4 cycles, resp_valid 5 cycles after accept; model memory holds 0xBEEF.
- Read addr 0x00123 -> OE_n low for 2 cycles; resp_rdata = 0xBEEF with resp_valid 3 cycles after accept; data_oe stays 0 throughout.
- Write 0x1234 with be = 2'b01 to a word holding 0xBEEF -> BE_n = 2'b10; readback = 0xBE34.
- Back-to-back: hold req_valid with read, write, read -> each accepted in the resp_valid cycle of the prior op; no cycle has OE_n = 0 and data_oe = 1 together.
- Assert Reset in the 2nd WR_PULSE cycle -> next cycle WE_n = 1, data_oe = 0, no resp_valid; a following read returns the unchanged prior value.
